// File: rtl/pc_fetch_controller.sv
// PC fetch controller: owns the fetch PC, issues instruction-memory requests,
// and applies branch/jump redirects. Redirects that arrive while a fetch is
// outstanding are held in a pending slot until the ack returns.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        IMemAck,
  output logic        IMemReq,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult,
  output logic        FetchValid,
  output logic [15:0] FetchCount
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic        pend;
  logic [31:0] pend_tgt;
  logic        redir;
  logic [31:0] redir_tgt;

  // Sequential next-PC; wraps naturally at 2^32.
  assign PCAddResult = PCResult + 32'd4;

  // Jump outranks branch; targets are always word aligned.
  always_comb begin
    redir     = Jump | BranchTaken;
    redir_tgt = (Jump ? JumpTarget : BranchTarget) & 32'hFFFF_FFFC;
  end

  // Fetch state machine; IMemReq and FetchValid are registered with the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      PCResult   <= RESET_PC;
      IMemReq    <= 1'b0;
      FetchValid <= 1'b0;
      FetchCount <= 16'h0000;
      pend       <= 1'b0;
      pend_tgt   <= 32'h0000_0000;
    end else begin
      FetchValid <= 1'b0;
      case (state)
        IDLE: begin
          if (redir) PCResult <= redir_tgt;
          state   <= FETCH;
          IMemReq <= 1'b1;
        end
        FETCH: begin
          if (IMemAck) begin
            if (redir) begin
              // A fresh redirect beats anything already pending.
              PCResult <= redir_tgt;
              pend     <= 1'b0;
            end else if (pend) begin
              // Instruction fetched on the wrong path: discard it.
              PCResult <= pend_tgt;
              pend     <= 1'b0;
            end else if (Stall) begin
              state   <= HOLD;
              IMemReq <= 1'b0;
            end else begin
              PCResult   <= PCAddResult;
              FetchValid <= 1'b1;
              FetchCount <= FetchCount + 16'd1;
            end
          end else if (redir) begin
            // Fetch still outstanding; remember the latest target.
            pend     <= 1'b1;
            pend_tgt <= redir_tgt;
          end
        end
        HOLD: begin
          if (redir) PCResult <= redir_tgt;
          if (!Stall) begin
            state   <= FETCH;
            IMemReq <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          IMemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: two instances, default reset PC and
// a reset PC at the top of the address space.
module tb_pc_fetch_controller;

  logic        clk, rst_n, stall, br, jmp, ack;
  logic [31:0] brt, jt;
  logic        req0, fv0, req1, fv1;
  logic [31:0] pc0, pca0, pc1, pca1;
  logic [15:0] cnt0, cnt1;
  int checks = 0;
  int failures = 0;

  pc_fetch_controller dut0 (
    .Clk(clk), .Reset(rst_n), .Stall(stall), .BranchTaken(br), .BranchTarget(brt),
    .Jump(jmp), .JumpTarget(jt), .IMemAck(ack), .IMemReq(req0), .PCResult(pc0),
    .PCAddResult(pca0), .FetchValid(fv0), .FetchCount(cnt0));

  pc_fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .Clk(clk), .Reset(rst_n), .Stall(stall), .BranchTaken(br), .BranchTarget(brt),
    .Jump(jmp), .JumpTarget(jt), .IMemAck(ack), .IMemReq(req1), .PCResult(pc1),
    .PCAddResult(pca1), .FetchValid(fv1), .FetchCount(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stall = 0; br = 0; jmp = 0; ack = 0; brt = 0; jt = 0;
  endtask

  // Reset, release, one edge: both instances end in FETCH.
  task automatic do_reset();
    clr_in();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 0;
    #3;
    checks++; if (pc0 !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc0, 32'h0); end
    checks++; if (req0 !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", req0); end
    checks++; if (fv0 !== 1'b0) begin failures++; $display("FAIL rst_fv got=%b exp=0", fv0); end
    checks++; if (cnt0 !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", cnt0); end
    checks++; if (pca0 !== 32'h4) begin failures++; $display("FAIL rst_pca got=%h exp=4", pca0); end
    step();
    rst_n = 1;
    #1;
    checks++; if (req0 !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", req0); end
    step();
    checks++; if (req0 !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", req0); end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc;
    do_reset();
    ack = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = 32'(i * 4);
      checks++; if (pc0 !== exp_pc) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc0, exp_pc); end
      checks++; if (fv0 !== 1'b1) begin failures++; $display("FAIL seq_fv%0d got=%b exp=1", i, fv0); end
    end
    checks++; if (cnt0 !== 16'd4) begin failures++; $display("FAIL seq_cnt got=%0d exp=4", cnt0); end
    ack = 0;
    step();
    checks++; if (fv0 !== 1'b0) begin failures++; $display("FAIL seq_fv_drop got=%b exp=0", fv0); end
  endtask

  task automatic test_stall();
    do_reset();
    ack = 1; step(); step();            // PC = 8
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc0 !== 32'h8) begin failures++; $display("FAIL hold_pc%0d got=%h exp=8", i, pc0); end
      checks++; if (req0 !== 1'b0) begin failures++; $display("FAIL hold_req%0d got=%b exp=0", i, req0); end
      checks++; if (fv0 !== 1'b0) begin failures++; $display("FAIL hold_fv%0d got=%b exp=0", i, fv0); end
    end
    stall = 0;                           // ack still high but ignored in HOLD
    step();
    checks++; if (pc0 !== 32'h8 || req0 !== 1'b1) begin failures++; $display("FAIL refetch got pc=%h req=%b exp pc=8 req=1", pc0, req0); end
    step();
    checks++; if (pc0 !== 32'hC || fv0 !== 1'b1) begin failures++; $display("FAIL resume got pc=%h fv=%b exp pc=c fv=1", pc0, fv0); end
    ack = 0;
    step();
    checks++; if (cnt0 !== 16'd3 || fv0 !== 1'b0) begin failures++; $display("FAIL stall_cnt got cnt=%0d fv=%b exp cnt=3 fv=0", cnt0, fv0); end
  endtask

  task automatic test_branch_pending();
    do_reset();
    ack = 1; repeat (4) step();         // PC = 16
    ack = 0; br = 1; brt = 32'h40;
    step();
    br = 0;
    checks++; if (pc0 !== 32'h10) begin failures++; $display("FAIL pend_pc got=%h exp=10", pc0); end
    step();
    ack = 1;
    step();
    checks++; if (pc0 !== 32'h40 || fv0 !== 1'b0) begin failures++; $display("FAIL pend_apply got pc=%h fv=%b exp pc=40 fv=0", pc0, fv0); end
    step();
    checks++; if (pc0 !== 32'h44 || fv0 !== 1'b1) begin failures++; $display("FAIL pend_clear got pc=%h fv=%b exp pc=44 fv=1", pc0, fv0); end
    // later redirect overwrites the latched one
    ack = 0; br = 1; brt = 32'h80;
    step();
    br = 0; jmp = 1; jt = 32'h90;
    step();
    jmp = 0; ack = 1;
    step();
    checks++; if (pc0 !== 32'h90 || fv0 !== 1'b0) begin failures++; $display("FAIL pend_overwrite got pc=%h fv=%b exp pc=90 fv=0", pc0, fv0); end
    ack = 0;
  endtask

  task automatic test_priority();
    do_reset();
    ack = 1; jmp = 1; jt = 32'h100; br = 1; brt = 32'h200;
    step();
    jmp = 0; br = 0;
    checks++; if (pc0 !== 32'h100 || fv0 !== 1'b0) begin failures++; $display("FAIL jmp_prio got pc=%h fv=%b exp pc=100 fv=0", pc0, fv0); end
    step();
    checks++; if (pc0 !== 32'h104 || fv0 !== 1'b1) begin failures++; $display("FAIL prio_nopend got pc=%h fv=%b exp pc=104 fv=1", pc0, fv0); end
    // pending target superseded by redirect arriving with the ack
    ack = 0; br = 1; brt = 32'h300;
    step();
    br = 0; jmp = 1; jt = 32'h400; ack = 1;
    step();
    jmp = 0;
    checks++; if (pc0 !== 32'h400 || fv0 !== 1'b0) begin failures++; $display("FAIL same_cycle_win got pc=%h fv=%b exp pc=400 fv=0", pc0, fv0); end
    step();
    checks++; if (pc0 !== 32'h404 || fv0 !== 1'b1) begin failures++; $display("FAIL same_cycle_clear got pc=%h fv=%b exp pc=404 fv=1", pc0, fv0); end
    ack = 0;
  endtask

  task automatic test_redirect_hold();
    do_reset();
    ack = 1; stall = 1;
    step();                              // HOLD at PC 0
    ack = 0; br = 1; brt = 32'h502;      // low bits dropped
    step();
    br = 0;
    checks++; if (pc0 !== 32'h500 || req0 !== 1'b0) begin failures++; $display("FAIL hold_redir got pc=%h req=%b exp pc=500 req=0", pc0, req0); end
    stall = 0;
    step();
    ack = 1;
    step();
    ack = 0;
    checks++; if (pc0 !== 32'h504 || fv0 !== 1'b1) begin failures++; $display("FAIL hold_redir_fetch got pc=%h fv=%b exp pc=504 fv=1", pc0, fv0); end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (pc1 !== 32'hFFFF_FFFC || pca1 !== 32'h0) begin failures++; $display("FAIL wrap_rst got pc=%h pca=%h exp pc=fffffffc pca=0", pc1, pca1); end
    ack = 1;
    step();
    checks++; if (pc1 !== 32'h0 || fv1 !== 1'b1) begin failures++; $display("FAIL wrap_pc got pc=%h fv=%b exp pc=0 fv=1", pc1, fv1); end
    jmp = 1; jt = 32'h103;
    step();
    jmp = 0; ack = 0;
    checks++; if (pc1 !== 32'h100) begin failures++; $display("FAIL align got=%h exp=100", pc1); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    ack = 1; step(); step();            // PC = 8, count 2
    ack = 0; br = 1; brt = 32'h700;
    step();                              // pending set
    br = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (pc0 !== 32'h0 || req0 !== 1'b0 || cnt0 !== 16'h0) begin failures++; $display("FAIL async_rst got pc=%h req=%b cnt=%0d exp pc=0 req=0 cnt=0", pc0, req0, cnt0); end
    step();
    rst_n = 1;
    step();
    ack = 1;
    step();
    ack = 0;
    checks++; if (pc0 !== 32'h4 || fv0 !== 1'b1) begin failures++; $display("FAIL stale_redir got pc=%h fv=%b exp pc=4 fv=1", pc0, fv0); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    ack = 1;
    repeat (65535) step();
    checks++; if (cnt0 !== 16'hFFFF) begin failures++; $display("FAIL cnt_max got=%h exp=ffff", cnt0); end
    step();
    ack = 0;
    checks++; if (cnt0 !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", cnt0); end
  endtask

  initial begin
    rst_n = 0;
    clr_in();
    test_reset();
    test_seq();
    test_stall();
    test_branch_pending();
    test_priority();
    test_redirect_hold();
    test_wrap();
    test_reset_pending();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_controller.md
PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Stall  input  1  downstream cannot accept an instruction this cycle.
REQ-005 BranchTaken  input  1  branch redirect request; one-cycle pulse.
REQ-006 BranchTarget  input  32  branch destination address.
REQ-007 Jump  input  1  jump redirect request; one-cycle pulse.
REQ-008 JumpTarget  input  32  jump destination address.
REQ-009 IMemAck  input  1  instruction memory has returned data for the current PCResult.
REQ-010 IMemReq  output  1  fetch request to instruction memory at PCResult.
REQ-011 PCResult  output  32  current fetch PC, registered.
REQ-012 PCAddResult  output  32  PCResult + 4, combinational.
REQ-013 FetchValid  output  1  one-cycle pulse: instruction at PCResult accepted downstream.
REQ-014 FetchCount  output  16  count of FetchValid pulses since reset.

Function
REQ-015 States SHALL be IDLE, FETCH and HOLD, in a registered state machine.
REQ-016 Reset SHALL set the state to IDLE, PCResult to RESET_PC, and IMemReq, FetchValid, FetchCount and the pending-redirect flag to 0.
REQ-017 IDLE SHALL transition to FETCH on the first clock after reset deassertion, with IMemReq=0 while in IDLE.
REQ-018 IMemReq SHALL be 1 in FETCH and 0 in IDLE and HOLD; IMemAck SHALL be ignored when IMemReq=0.
REQ-019 PCAddResult SHALL be PCResult+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-020 Redirect target selection SHALL give Jump priority over BranchTaken (Jump -> JumpTarget, else BranchTaken -> BranchTarget), with target bits [1:0] forced to 0.
REQ-021 In FETCH with IMemAck=1, no redirect this cycle, no pending redirect and Stall=0: PCResult<=PCAddResult, FetchValid=1 next cycle, FetchCount+1, remain FETCH (back-to-back fetch).
REQ-022 In FETCH with IMemAck=1 and Stall=1 (no redirect): PCResult unchanged, FetchValid=0, go to HOLD.
REQ-023 HOLD SHALL return to FETCH on the first cycle with Stall=0, re-fetching the same PCResult.
REQ-024 A redirect in FETCH with IMemAck=0 SHALL latch the selected target and set the pending flag; a later redirect before ack SHALL overwrite the latched target.
REQ-025 In FETCH with IMemAck=1 and the pending flag set: PCResult<=latched target, FetchValid=0 (fetched instruction discarded), pending cleared, remain FETCH regardless of Stall.
REQ-026 A redirect in the same cycle as IMemAck=1 SHALL win over a pending target: PCResult<=new target, FetchValid=0, pending cleared.
REQ-027 A redirect in IDLE or HOLD SHALL load PCResult with the target on the next edge; the state then follows Stall as usual.
REQ-028 FetchValid SHALL be registered, high for exactly one cycle per accepted instruction, and never high in consecutive cycles unless consecutive acks are accepted.
REQ-029 FetchCount SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 Latency: ack to FetchValid SHALL be 1 cycle; ack to updated PCResult SHALL be 1 cycle.

Reset
REQ-031 Reset asserted mid-FETCH or mid-HOLD SHALL immediately (asynchronously) force all REQ-016 values, drop any pending redirect and drop IMemReq.
REQ-032 Reset deassertion SHALL be taken synchronously; the first fetch request SHALL appear in the second cycle after deassertion.

Verification
REQ-033 Reset, then ack every cycle with Stall=0 -> PCResult 0,4,8,12; FetchValid high every cycle after the first ack; FetchCount=4 after 4 acks.
REQ-034 PC=8: ack with Stall=1 for 3 cycles, then Stall=0 and ack -> PCResult stays 8 and IMemReq=0 in HOLD, then PC=12 with one FetchValid.
REQ-035 PC=16, IMemAck=0: BranchTaken with target 0x40, then ack two cycles later -> FetchValid=0 and PCResult=0x40.
REQ-036 Jump (0x100) and BranchTaken (0x200) in the same cycle as ack -> PCResult=0x100, FetchValid=0, pending clear.
REQ-037 RESET_PC=0xFFFFFFFC, one ack -> PCResult=0x00000000; target 0x103 -> PCResult=0x100.
REQ-038 Reset pulsed low while a redirect is pending -> PCResult=RESET_PC, IMemReq=0, FetchCount=0, and no stale redirect applied after restart.
